dmem_arbiter: RTL

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arb_pkg.sv | 20 ++
 rtl/dmem_arb_starve_ctr.sv | 38 +++
 rtl/dmem_arbiter.sv | 137 +++++++++++++
 3 files changed

// File: rtl/dmem_arb_pkg.sv
// ============================================================================
// Module   : dmem_arb_pkg
// Purpose  : Shared widths and FSM state encoding for the data-memory arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package dmem_arb_pkg;

    localparam int c_ADDR_W_DEF = 9;
    localparam int c_DATA_W_DEF = 32;

    typedef enum logic [0:0] {
        ST_IDLE      = 1'b0,
        ST_ACC_BURST = 1'b1
    } state_t;

endpackage

`default_nettype wire

// File: rtl/dmem_arb_starve_ctr.sv
// ============================================================================
// Module   : dmem_arb_starve_ctr
// Purpose  : Saturating count of consecutive contested cycles lost by the
//            accelerator; at_max tells the arbiter to let it through.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_arb_starve_ctr #(
    parameter int STARVE_MAX = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic clr,
    output logic at_max
);

    localparam int c_CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [c_CNT_W-1:0] c_MAX = c_CNT_W'(STARVE_MAX);

    logic [c_CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (inc && (r_cnt != c_MAX)) begin
            r_cnt <= r_cnt + c_CNT_W'(1);
        end
    end

    assign at_max = (r_cnt == c_MAX);

endmodule

`default_nettype wire

// File: rtl/dmem_arbiter.sv
// ============================================================================
// Module   : dmem_arbiter
// Purpose  : Single-port data-memory arbiter between CPU and accelerator with
//            capped accelerator bursts. Define DMEM_ARB_FAIR_EN to enable
//            anti-starvation of the accelerator.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W     = c_ADDR_W_DEF,
    parameter int DATA_W     = c_DATA_W_DEF,
    parameter int MAX_BURST  = 16,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_wen,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_stall,
    input  logic              acc_req,
    input  logic              acc_wen,
    input  logic              acc_last,
    input  logic [ADDR_W-1:0] acc_addr,
    input  logic [DATA_W-1:0] acc_wdata,
    output logic              acc_gnt,
    output logic [DATA_W-1:0] acc_rdata,
    output logic              mem_wen,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    input  logic [DATA_W-1:0] mem_dout
);

    localparam int c_BEAT_W = $clog2(MAX_BURST + 1);
    localparam logic [c_BEAT_W-1:0] c_BEAT_MAX = c_BEAT_W'(MAX_BURST);

    if ((MAX_BURST < 1) || (STARVE_MAX < 1)) begin : g_bad_param
        $error("dmem_arbiter: MAX_BURST and STARVE_MAX must be at least 1");
    end

    state_t              r_state;
    logic [c_BEAT_W-1:0] r_beat;
    logic [c_BEAT_W-1:0] w_beat_next;
    logic                w_cpu_gnt;
    logic                w_acc_gnt;
    logic                w_force;

`ifdef DMEM_ARB_FAIR_EN
    logic w_at_max;
    logic w_starve_inc;
    logic w_starve_clr;

    assign w_starve_inc = (r_state == ST_IDLE) & cpu_req & acc_req & w_cpu_gnt;
    assign w_starve_clr = w_acc_gnt | ~acc_req;

    dmem_arb_starve_ctr #(
        .STARVE_MAX (STARVE_MAX)
    ) u_starve_ctr (
        .clk    (clk),
        .rst    (rst),
        .inc    (w_starve_inc),
        .clr    (w_starve_clr),
        .at_max (w_at_max)
    );

    // Only overrides the CPU when the accelerator is actually asking.
    assign w_force = w_at_max & acc_req;
`else
    assign w_force = 1'b0;
`endif

    // Grants are combinational so a read returns mem_dout in its own cycle.
    always_comb begin
        w_cpu_gnt = 1'b0;
        w_acc_gnt = 1'b0;
        if (!rst) begin
            case (r_state)
                ST_IDLE: begin
                    if (cpu_req && !w_force) begin
                        w_cpu_gnt = 1'b1;
                    end else begin
                        w_acc_gnt = acc_req;
                    end
                end
                ST_ACC_BURST: w_acc_gnt = acc_req;
                default:      w_acc_gnt = 1'b0;
            endcase
        end
    end

    assign w_beat_next = r_beat + c_BEAT_W'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_beat  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    // The entry beat counts as beat one of the burst.
                    if (w_acc_gnt && !acc_last && (MAX_BURST > 1)) begin
                        r_state <= ST_ACC_BURST;
                        r_beat  <= c_BEAT_W'(1);
                    end
                end
                ST_ACC_BURST: begin
                    if (!acc_req || acc_last || (w_beat_next == c_BEAT_MAX)) begin
                        r_state <= ST_IDLE;
                        r_beat  <= '0;
                    end else begin
                        r_beat  <= w_beat_next;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_beat  <= '0;
                end
            endcase
        end
    end

    assign cpu_stall = ~rst & cpu_req & ~w_cpu_gnt;
    assign acc_gnt   = w_acc_gnt;
    assign mem_wen   = (w_cpu_gnt & cpu_wen) | (w_acc_gnt & acc_wen);
    assign mem_addr  = w_cpu_gnt ? cpu_addr  : acc_addr;
    assign mem_din   = w_cpu_gnt ? cpu_wdata : acc_wdata;
    assign cpu_rdata = mem_dout;
    assign acc_rdata = mem_dout;

endmodule

`default_nettype wire
